// File: rtl/wb_master_arbiter.sv
// Round-robin N-master Wishbone arbiter; ownership is locked for a whole cyc.
// Optional bus-timeout watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_master_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS*3-1:0]        m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]        m_bte_i,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic [NUM_MASTERS-1:0]          m_rty_o,
  output logic [DATA_W-1:0]               m_dat_o,
  output logic                            wb_cyc_o,
  output logic                            wb_stb_o,
  output logic                            wb_we_o,
  output logic [ADDR_W-1:0]               wb_adr_o,
  output logic [DATA_W-1:0]               wb_dat_o,
  output logic [DATA_W/8-1:0]             wb_sel_o,
  output logic [2:0]                      wb_cti_o,
  output logic [1:0]                      wb_bte_o,
  input  logic                            wb_ack_i,
  input  logic                            wb_err_i,
  input  logic                            wb_rty_i,
  input  logic [DATA_W-1:0]               wb_dat_i,
  output logic [NUM_MASTERS-1:0]          grant_o,
  output logic                            timeout_o,
  output logic [1:0]                      state_o
);

  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    BACKOFF = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] g_q, g_d, ptr_q, ptr_d, winner, g_next;
  logic          found;
  logic          own_cyc, own_stb;
  logic          fire;
  int            idx;

  assign own_cyc = m_cyc_i[g_q];
  assign own_stb = m_stb_i[g_q];
  assign g_next  = (int'(g_q) == NUM_MASTERS - 1) ? '0 : g_q + 1'b1;
  assign state_o = state_q;

  // First requester at or above ptr, wrapping around.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = (int'(ptr_q) + i) % NUM_MASTERS;
      if (!found && m_cyc_i[GW'(idx)]) begin
        winner = GW'(idx);
        found  = 1'b1;
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic          resp;

  assign resp = wb_ack_i | wb_err_i | wb_rty_i;
  // cnt_q counts earlier unanswered cycles, so cnt_q+1 includes the current one.
  assign fire = (state_q == OWN) && own_cyc && own_stb && !resp &&
                (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (state_q == OWN && own_cyc && own_stb && !resp && !fire)
      cnt_q <= cnt_q + 1'b1;
    else
      cnt_q <= '0;
  end
`else
  assign fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWN;
          g_d     = winner;
        end
      end
      OWN: begin
        if (!own_cyc) begin
          state_d = IDLE;
          ptr_d   = g_next;
        end else if (fire) begin
          state_d = BACKOFF;
        end
      end
      BACKOFF: begin
        // A timed-out owner also passes priority on, keeping rotation fair.
        if (!own_cyc) begin
          state_d = IDLE;
          ptr_d   = g_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_ack_o   = '0;
    m_err_o   = '0;
    m_rty_o   = '0;
    m_dat_o   = '0;
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_adr_o  = '0;
    wb_dat_o  = '0;
    wb_sel_o  = '0;
    wb_cti_o  = '0;
    wb_bte_o  = '0;
    grant_o   = '0;
    timeout_o = fire;
    if (state_q == OWN) begin
      wb_cyc_o       = own_cyc & ~fire;
      wb_stb_o       = own_stb & ~fire;
      wb_we_o        = m_we_i[g_q];
      wb_adr_o       = m_adr_i[int'(g_q)*ADDR_W +: ADDR_W];
      wb_dat_o       = m_dat_i[int'(g_q)*DATA_W +: DATA_W];
      wb_sel_o       = m_sel_i[int'(g_q)*SW +: SW];
      wb_cti_o       = m_cti_i[int'(g_q)*3 +: 3];
      wb_bte_o       = m_bte_i[int'(g_q)*2 +: 2];
      m_dat_o        = wb_dat_i;
      m_ack_o[g_q]   = wb_ack_i;
      m_err_o[g_q]   = wb_err_i | fire;
      m_rty_o[g_q]   = wb_rty_i;
      grant_o[g_q]   = 1'b1;
    end
  end

endmodule
